// File: rtl/logic_gate_pipe.sv
// Bitwise logic unit with a valid/ready handshake and a two-entry output buffer.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, a, b, op on the request side;
// out_valid/out_ready, y, zero, parity on the result side; count = results delivered.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNTW-1:0]  count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             deliver;
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             res_par;
    logic [WIDTH-1:0] skid_y;
    logic             skid_zero;
    logic             skid_par;

    // Both handshake signals come straight from the state register.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    always_comb begin
        res = '0;
        unique case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: res = a ^ b;
            3'b011: res = ~(a & b);
            3'b100: res = ~(a | b);
            3'b101: res = ~(a ^ b);
            3'b110: res = ~a;
            3'b111: res = a;
            default: res = '0;
        endcase
    end

    assign res_zero = ~|res;
    assign res_par  = ^res;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && !deliver) begin
                    state_nxt = FULL;
                end else if (deliver && !accept) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a delivery can happen.
                if (deliver) begin
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
            skid_y    <= '0;
            skid_zero <= 1'b1;
            skid_par  <= 1'b0;
        end else begin
            if (deliver && state == FULL) begin
                y      <= skid_y;
                zero   <= skid_zero;
                parity <= skid_par;
            end else if (accept && (state == EMPTY || deliver)) begin
                y      <= res;
                zero   <= res_zero;
                parity <= res_par;
            end
            // Output register busy and not draining: park the result.
            if (accept && state == ONE && !deliver) begin
                skid_y    <= res;
                skid_zero <= res_zero;
                skid_par  <= res_par;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (deliver && count != {CNTW{1'b1}}) begin
            count <= count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed-vector bench for logic_gate_pipe: op table, backpressure,
// reset mid-stream, streaming throughput and counter saturation.
module tb_logic_gate_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;
    logic       parity;
    logic [15:0] count;

    logic       in_valid2;
    logic       in_ready2;
    logic [7:0] a2;
    logic       out_valid2;
    logic [7:0] y2;
    logic       zero2;
    logic       parity2;
    logic [3:0] count2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       zero;
        logic       parity;
    } vec_t;

    vec_t tbl[13];

    logic_gate_pipe #(.WIDTH(8), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .parity(parity), .count(count)
    );

    logic_gate_pipe #(.WIDTH(8), .CNTW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(8'h00), .op(3'b111),
        .out_valid(out_valid2), .out_ready(1'b1),
        .y(y2), .zero(zero2), .parity(parity2), .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{3'b000, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0};
        tbl[1]  = '{3'b001, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0};
        tbl[2]  = '{3'b010, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0};
        tbl[3]  = '{3'b011, 8'hA5, 8'h3C, 8'hDB, 1'b0, 1'b0};
        tbl[4]  = '{3'b100, 8'hA5, 8'h3C, 8'h42, 1'b0, 1'b0};
        tbl[5]  = '{3'b101, 8'hA5, 8'h3C, 8'h66, 1'b0, 1'b0};
        tbl[6]  = '{3'b110, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0};
        tbl[7]  = '{3'b111, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0};
        tbl[8]  = '{3'b010, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{3'b111, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1};
        tbl[10] = '{3'b100, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
        tbl[11] = '{3'b110, 8'hFE, 8'h55, 8'h01, 1'b0, 1'b1};
        tbl[12] = '{3'b011, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = 8'h33;
        b = 8'h0F;
        op = 3'b001;
        in_valid2 = 1'b0;
        a2 = 8'h00;

        // Reset with traffic presented: must be ignored.
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_y", 64'(y), 64'h00);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_parity", 64'(parity), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_count_sat", 64'(count2), 64'd0);

        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // Op table: one request per cycle, out_ready held high.
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            a = tbl[i].a;
            b = tbl[i].b;
            op = tbl[i].op;
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("tbl%0d_y", i), 64'(y), 64'(tbl[i].y));
            chk($sformatf("tbl%0d_zero", i), 64'(zero), 64'(tbl[i].zero));
            chk($sformatf("tbl%0d_parity", i), 64'(parity), 64'(tbl[i].parity));
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(i));
        end
        step();
        chk("tbl_drain_valid", 64'(out_valid), 64'd0);
        chk("tbl_count", 64'(count), 64'd13);

        // Backpressure: two fit, third waits until the consumer drains.
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 3'b111;
        b = 8'h00;
        a = 8'h01;
        step();
        chk("bp_first_y", 64'(y), 64'h01);
        chk("bp_first_ready", 64'(in_ready), 64'd1);
        a = 8'h02;
        step();
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_full_y", 64'(y), 64'h01);
        a = 8'h04;
        step();
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_y", 64'(y), 64'h01);
        chk("bp_hold_parity", 64'(parity), 64'd1);
        step();
        chk("bp_hold2_y", 64'(y), 64'h01);
        chk("bp_hold_count", 64'(count), 64'd13);
        out_ready = 1'b1;
        step();
        chk("bp_d1_y", 64'(y), 64'h02);
        chk("bp_d1_ready", 64'(in_ready), 64'd1);
        chk("bp_d1_count", 64'(count), 64'd14);
        step();
        in_valid = 1'b0;
        chk("bp_d2_y", 64'(y), 64'h04);
        chk("bp_d2_valid", 64'(out_valid), 64'd1);
        chk("bp_d2_count", 64'(count), 64'd15);
        step();
        chk("bp_d3_valid", 64'(out_valid), 64'd0);
        chk("bp_d3_count", 64'(count), 64'd16);

        // Fill both entries, then reset for one edge.
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'h11;
        step();
        a = 8'h22;
        step();
        chk("mr_full_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        out_ready = 1'b1;
        a = 8'h33;
        step();
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_y", 64'(y), 64'h00);
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mr_stale%0d", i), 64'(out_valid), 64'd0);
        end
        chk("mr_stale_count", 64'(count), 64'd0);
        in_valid = 1'b1;
        a = 8'h77;
        step();
        in_valid = 1'b0;
        chk("mr_new_y", 64'(y), 64'h77);
        step();
        chk("mr_new_count", 64'(count), 64'd1);
        chk("mr_new_drained", 64'(out_valid), 64'd0);

        // Streaming: 100 requests back to back after a fresh reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 3'b111;
        a = 8'd1;
        for (int j = 1; j <= 100; j++) begin
            step();
            chk($sformatf("st%0d_valid", j), 64'(out_valid), 64'd1);
            chk($sformatf("st%0d_y", j), 64'(y), 64'(j));
            if (j < 100) begin
                a = 8'(j + 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        step();
        chk("st_count", 64'(count), 64'd100);
        chk("st_drained", 64'(out_valid), 64'd0);

        // Saturation on the 4-bit counter.
        in_valid2 = 1'b1;
        for (int j = 1; j <= 25; j++) begin
            a2 = 8'(j);
            step();
            chk($sformatf("sat%0d_count", j), 64'(count2),
                64'((j - 1 > 15) ? 15 : j - 1));
            if (j == 20) begin
                in_valid2 = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNTW, default 16, giving the transaction-counter width in bits.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset; it SHALL be synchronous and active-low.
REQ-005 Port in_valid  input  1  SHALL indicate that a, b and op hold a valid request.
REQ-006 Port in_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 Ports a and b  input  WIDTH  SHALL be the operands.
REQ-008 Port op  input  3  SHALL select the operation.
REQ-009 Port out_valid  output  1  SHALL indicate that y, zero and parity hold a valid result.
REQ-010 Port out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-011 Port y  output  WIDTH  SHALL be the result.
REQ-012 Port zero  output  1  SHALL be 1 when y is all zeros.
REQ-013 Port parity  output  1  SHALL be the XOR-reduction of y.
REQ-014 Port count  output  CNTW  SHALL be the number of results delivered.

Function
REQ-015 The op encoding SHALL be:
- 000 AND
- 001 OR
- 010 XOR
- 011 NAND
- 100 NOR
- 101 XNOR
- 110 NOT a (b ignored)
- 111 PASS a (b ignored)
REQ-016 All operations SHALL be bitwise across WIDTH, and y SHALL be exactly WIDTH bits with no extension or truncation.
REQ-017 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-018 A result SHALL be delivered on a rising edge where out_valid=1 and out_ready=1.
REQ-019 The block SHALL contain a two-entry buffer made of an output register and a skid register.
REQ-020 in_ready SHALL be a registered signal, equal to 1 exactly when the skid register is empty.
REQ-021 An accepted request SHALL compute y, zero and parity in the cycle of acceptance.
- If the output register is empty, or is being drained in that cycle, the result SHALL load into the output register.
- Otherwise the result SHALL load into the skid register.
REQ-022 Latency SHALL be 1 cycle: out_valid rises on the edge after acceptance when the output register was empty or draining.
REQ-023 When the output register drains and the skid register is full, the skid contents SHALL move to the output register on that edge, and the skid register SHALL become empty.
REQ-024 With in_valid=1 and out_ready=1 held continuously, the block SHALL sustain one result per cycle.
REQ-025 Simultaneous accept and deliver with the skid register full SHALL NOT occur, because in_ready=0 in that state.
REQ-026 Results SHALL be delivered in acceptance order, with none lost or duplicated.
REQ-027 While out_valid=1 and out_ready=0, y, zero and parity SHALL hold stable.
REQ-028 Buffer-state transitions:
- EMPTY -> ONE on accept without deliver.
- ONE -> FULL on accept without deliver.
- FULL -> ONE on deliver.
- ONE -> EMPTY on deliver without accept.
- Every other combination SHALL hold the current state.
REQ-029 count SHALL increment by 1 on every delivery and SHALL saturate at 2^CNTW-1 with no wrap-around.
REQ-030 Inputs SHALL be ignored whenever in_valid=0 or in_ready=0.

Reset
REQ-031 When rst_n=0 at a rising edge, the following SHALL hold after that edge:
- out_valid=0
- in_ready=1
- y=0
- zero=1
- parity=0
- count=0
- skid register empty
REQ-032 Reset asserted mid-operation SHALL discard all buffered results, with no delivery occurring on that edge.
REQ-033 in_valid and out_ready SHALL be ignored while rst_n=0.
REQ-034 Reset SHALL have no effect between clock edges.

Verification
REQ-035 Exhaustive op sweep, WIDTH=8, a=8'hA5, b=8'h3C, out_ready=1, one request per op -> y shall be, in op order 000..111:
- 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h5A, 8'hA5
- zero=0 for every result
- parity=0,0,0,0,0,0,0,0 (every result has an even number of ones)
REQ-036 Backpressure: out_ready=0, then three back-to-back requests (a=01, 02, 04; op=111):
- First two are accepted.
- in_ready=0 from the cycle after the second acceptance; the third waits.
- Raising out_ready delivers 01, 02, 04 in order.
REQ-037 Streaming: 100 requests with in_valid=1 and out_ready=1 continuously -> 100 results on 100 consecutive cycles after 1-cycle latency, and count=100.
REQ-038 Flags: a=8'hFF, b=8'hFF, op=010 -> y=8'h00, zero=1, parity=0; a=8'h01, op=111 -> y=8'h01, zero=0, parity=1.
REQ-039 Reset mid-stream: rst_n=0 for one edge with the skid register full -> out_valid=0, in_ready=1 and count=0 on the following cycle, and no stale result ever appears.
REQ-040 Saturation: CNTW=4, deliver 20 results -> count=15 after the 15th delivery and held at 15 thereafter.
